// File: rtl/pc_stack_pkg.sv
// Shared definitions for the fetch program counter and its return-address stack.
package pc_pkg;

  localparam int unsigned DEF_ADDR_W      = 12;
  localparam int unsigned DEF_STACK_DEPTH = 8;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_RET,
    PC_CALL,
    PC_JMP,
    PC_BR,
    PC_INC
  } pc_sel_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Control requests from decode/execute and the PC/stack status seen by fetch.
interface pc_stack_if
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH
);

  localparam int unsigned CNT_W = cnt_width(STACK_DEPTH);

  logic              stall;
  logic              jmpEn;
  logic [ADDR_W-1:0] jmpAddr;
  logic              brEn;
  logic [ADDR_W-1:0] brOffset;
  logic              callEn;
  logic [ADDR_W-1:0] callAddr;
  logic              retEn;
  logic [ADDR_W-1:0] currAddr;
  logic [CNT_W-1:0]  stackCount;
  logic              stackOvf;
  logic              stackUdf;

  modport master (
    output stall, jmpEn, jmpAddr, brEn, brOffset, callEn, callAddr, retEn,
    input  currAddr, stackCount, stackOvf, stackUdf
  );

  modport slave (
    input  stall, jmpEn, jmpAddr, brEn, brOffset, callEn, callAddr, retEn,
    output currAddr, stackCount, stackOvf, stackUdf
  );

endinterface

// File: rtl/pc_stack_ret_stack.sv
// Return-address LIFO; count saturates at both ends, storage is not reset.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_STACK_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          pushData,
  output logic [DATA_W-1:0]          topData,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  top_idx;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_idx  = cnt_q[PTR_W-1:0];
  // When empty this points at the last slot; the value is unused then.
  assign top_idx = PTR_W'(cnt_q - CNT_W'(1));
  assign topData = mem_q[top_idx];
  assign count   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wr_idx] <= pushData;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Fetch program counter with stall, jump, relative branch and call/return stack.
module pc_stack
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter int unsigned       STACK_DEPTH = DEF_STACK_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic       clk,
  input  logic       rst,
  pc_stack_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(STACK_DEPTH);

  pc_sel_e           sel;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] add_b;
  logic [ADDR_W-1:0] pc_sum;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              push, pop;
  logic [ADDR_W-1:0] top_data;
  logic [CNT_W-1:0]  count;
  logic              full, empty;

  always_comb begin
    sel = PC_INC;
    if (bus.stall) begin
      sel = PC_HOLD;
    end else if (bus.retEn) begin
      sel = PC_RET;
    end else if (bus.callEn) begin
      sel = PC_CALL;
    end else if (bus.jmpEn) begin
      sel = PC_JMP;
    end else if (bus.brEn) begin
      sel = PC_BR;
    end
  end

  // One adder serves both the +1 successor (also the pushed return address) and branches.
  assign add_b  = (sel == PC_BR) ? bus.brOffset : ADDR_W'(1);
  assign pc_sum = pc_q + add_b;

  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    push  = 1'b0;
    pop   = 1'b0;
    unique case (sel)
      PC_HOLD: ;
      PC_RET: begin
        if (!empty) begin
          pop  = 1'b1;
          pc_d = top_data;
        end else begin
          udf_d = 1'b1;
          pc_d  = pc_sum;
        end
      end
      PC_CALL: begin
        if (!full) begin
          push = 1'b1;
          pc_d = bus.callAddr;
        end else begin
          ovf_d = 1'b1;
          pc_d  = pc_sum;
        end
      end
      PC_JMP:  pc_d = bus.jmpAddr;
      PC_BR:   pc_d = pc_sum;
      PC_INC:  pc_d = pc_sum;
      default: pc_d = pc_sum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_ADDR;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  pc_ret_stack #(
    .DATA_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_ret_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .pushData (pc_sum),
    .topData  (top_data),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign bus.currAddr   = pc_q;
  assign bus.stackCount = count;
  assign bus.stackOvf   = ovf_q;
  assign bus.stackUdf   = udf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Drives two pc_stack configurations in lockstep against a queue-based reference model.
module tb_pc_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, jmpEn, brEn, callEn, retEn;
  logic [15:0] jmpAddr, brOffset, callAddr;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  pc_stack_if #(.ADDR_W(12), .STACK_DEPTH(8)) if0 ();
  pc_stack_if #(.ADDR_W(16), .STACK_DEPTH(4)) if1 ();

  assign if0.stall    = stall;
  assign if0.jmpEn    = jmpEn;
  assign if0.jmpAddr  = jmpAddr[11:0];
  assign if0.brEn     = brEn;
  assign if0.brOffset = brOffset[11:0];
  assign if0.callEn   = callEn;
  assign if0.callAddr = callAddr[11:0];
  assign if0.retEn    = retEn;

  assign if1.stall    = stall;
  assign if1.jmpEn    = jmpEn;
  assign if1.jmpAddr  = jmpAddr;
  assign if1.brEn     = brEn;
  assign if1.brOffset = brOffset;
  assign if1.callEn   = callEn;
  assign if1.callAddr = callAddr;
  assign if1.retEn    = retEn;

  pc_stack #(.ADDR_W(12), .STACK_DEPTH(8), .RESET_ADDR(12'h000)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  pc_stack #(.ADDR_W(16), .STACK_DEPTH(4), .RESET_ADDR(16'h0100)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  // Reference model: PC as a masked integer, stack as a queue.
  int unsigned m_pc    [2];
  int unsigned m_mask  [2] = '{32'h0FFF, 32'hFFFF};
  int unsigned m_depth [2] = '{8, 4};
  int unsigned m_reset [2] = '{32'h000, 32'h100};
  bit          m_ovf   [2];
  bit          m_udf   [2];
  int unsigned m_stk   [2][$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int unsigned nxt;
    nxt = (m_pc[k] + 1) & m_mask[k];
    if (rst) begin
      m_pc[k]  = m_reset[k];
      m_stk[k].delete();
      m_ovf[k] = 1'b0;
      m_udf[k] = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (retEn) begin
      if (m_stk[k].size() > 0) m_pc[k] = m_stk[k].pop_back();
      else begin
        m_udf[k] = 1'b1;
        m_pc[k]  = nxt;
      end
    end else if (callEn) begin
      if (m_stk[k].size() < m_depth[k]) begin
        m_stk[k].push_back(nxt);
        m_pc[k] = callAddr & m_mask[k];
      end else begin
        m_ovf[k] = 1'b1;
        m_pc[k]  = nxt;
      end
    end else if (jmpEn) begin
      m_pc[k] = jmpAddr & m_mask[k];
    end else if (brEn) begin
      m_pc[k] = (m_pc[k] + brOffset) & m_mask[k];
    end else begin
      m_pc[k] = nxt;
    end
  endtask

  task automatic check_all();
    check_eq("pc0",  32'(if0.currAddr),   m_pc[0]);
    check_eq("cnt0", 32'(if0.stackCount), m_stk[0].size());
    check_eq("ovf0", 32'(if0.stackOvf),   32'(m_ovf[0]));
    check_eq("udf0", 32'(if0.stackUdf),   32'(m_udf[0]));
    check_eq("pc1",  32'(if1.currAddr),   m_pc[1]);
    check_eq("cnt1", 32'(if1.stackCount), m_stk[1].size());
    check_eq("ovf1", 32'(if1.stackOvf),   32'(m_ovf[1]));
    check_eq("udf1", 32'(if1.stackUdf),   32'(m_udf[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  task automatic clr();
    rst = 1'b0; stall = 1'b0; jmpEn = 1'b0; brEn = 1'b0; callEn = 1'b0; retEn = 1'b0;
    jmpAddr = '0; brOffset = '0; callAddr = '0;
  endtask

  task automatic do_call(input logic [15:0] a);
    clr(); callEn = 1'b1; callAddr = a; tick();
  endtask

  task automatic do_ret();
    clr(); retEn = 1'b1; tick();
  endtask

  initial begin
    int unsigned exp_ret [3];
    exp_ret = '{32'h401, 32'h301, 32'h012};

    clr(); rst = 1'b1; tick();
    check_eq("rst_pc", 32'(if0.currAddr), 32'h0);
    check_eq("rst_pc1", 32'(if1.currAddr), 32'h100);
    for (int i = 1; i <= 5; i++) begin
      clr(); tick();
      check_eq("idle_inc", 32'(if0.currAddr), 32'(i));
    end

    clr(); jmpEn = 1'b1; jmpAddr = 16'h00F0; tick();
    check_eq("jmp", 32'(if0.currAddr), 32'h0F0);
    clr(); tick();
    check_eq("jmp_inc", 32'(if0.currAddr), 32'h0F1);
    clr(); brEn = 1'b1; brOffset = 16'hFFF0; tick();
    check_eq("br_neg", 32'(if0.currAddr), 32'h0E1);
    clr(); jmpEn = 1'b1; jmpAddr = 16'h0002; tick();
    clr(); brEn = 1'b1; brOffset = 16'hFFFC; tick();
    check_eq("br_wrap", 32'(if0.currAddr), 32'hFFE);
    clr(); tick();
    clr(); tick();
    check_eq("inc_wrap", 32'(if0.currAddr), 32'h000);

    clr(); jmpEn = 1'b1; jmpAddr = 16'h0010; tick();
    do_call(16'h0200);
    check_eq("call_pc", 32'(if0.currAddr), 32'h200);
    check_eq("call_cnt", 32'(if0.stackCount), 32'd1);
    clr(); tick(); tick();
    do_ret();
    check_eq("ret_pc", 32'(if0.currAddr), 32'h011);
    for (int i = 0; i < 3; i++) do_call(16'(32'h300 + 32'h100 * i));
    for (int i = 0; i < 3; i++) begin
      do_ret();
      check_eq("nest_ret", 32'(if0.currAddr), exp_ret[i]);
    end

    for (int i = 0; i < 8; i++) do_call(16'(32'h100 + 32'h10 * i));
    check_eq("fill_cnt", 32'(if0.stackCount), 32'd8);
    do_call(16'h07FF);
    check_eq("ovf_flag", 32'(if0.stackOvf), 32'd1);
    check_eq("ovf_pc", 32'(if0.currAddr), 32'h171);
    for (int i = 0; i < 9; i++) do_ret();
    check_eq("udf_flag", 32'(if0.stackUdf), 32'd1);
    check_eq("udf_pc", 32'(if0.currAddr), 32'h014);
    clr(); tick();
    check_eq("ovf_sticky", 32'(if0.stackOvf), 32'd1);

    for (int i = 0; i < 3; i++) begin
      clr(); stall = 1'b1; jmpEn = i[0]; callEn = ~i[0]; retEn = i[1];
      jmpAddr = 16'h0ABC; callAddr = 16'h0DEF; tick();
      check_eq("stall_pc", 32'(if0.currAddr), 32'h015);
    end

    do_call(16'h0600);
    do_call(16'h0700);
    clr(); callEn = 1'b1; retEn = 1'b1; callAddr = 16'h07AA; tick();
    check_eq("callret_pc", 32'(if0.currAddr), 32'h601);
    check_eq("callret_cnt", 32'(if0.stackCount), 32'd1);
    do_call(16'h0800);
    do_call(16'h0900);
    do_call(16'h0A00);
    check_eq("pre_rst_cnt", 32'(if0.stackCount), 32'd4);
    clr(); rst = 1'b1; callEn = 1'b1; callAddr = 16'h0BBB; tick();
    check_eq("rstcall_pc", 32'(if0.currAddr), 32'h000);
    check_eq("rstcall_cnt", 32'(if0.stackCount), 32'd0);
    check_eq("rstcall_pc1", 32'(if1.currAddr), 32'h100);

    for (int n = 0; n < 3000; n++) begin
      clr();
      rst      = ($urandom_range(0, 99) < 2);
      stall    = ($urandom_range(0, 7) == 0);
      retEn    = ($urandom_range(0, 3) == 0);
      callEn   = ($urandom_range(0, 3) == 0);
      jmpEn    = ($urandom_range(0, 5) == 0);
      brEn     = ($urandom_range(0, 4) == 0);
      jmpAddr  = 16'($urandom);
      brOffset = 16'($urandom);
      callAddr = 16'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter with stall, absolute jump, PC-relative branch, and a hardware call/return stack.
- Successor to the 12-bit fetch PC: generalised address width, adds relative branching, subroutine linkage and stack fault flags.
- Sits at the front of the fetch stage. `currAddr` drives instruction-memory address; control inputs come from decode/execute.

Parameters:
- ADDR_W, 12, address width in bits; all PC arithmetic is modulo 2^ADDR_W.
- STACK_DEPTH, 8, number of return-address entries; power of two, >= 2.
- RESET_ADDR, 0, value loaded into `currAddr` on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and stack unchanged this cycle.
- jmpEn  input  1  absolute jump request.
- jmpAddr  input  ADDR_W  jump target.
- brEn  input  1  relative branch request.
- brOffset  input  ADDR_W  signed two's-complement offset, relative to `currAddr`.
- callEn  input  1  call request: push return address, load `callAddr`.
- callAddr  input  ADDR_W  call target.
- retEn  input  1  return request: pop stack into PC.
- currAddr  output  ADDR_W  registered current PC.
- stackCount  output  $clog2(STACK_DEPTH)+1  number of valid stack entries.
- stackOvf  output  1  sticky flag: call attempted while stack full.
- stackUdf  output  1  sticky flag: return attempted while stack empty.

Behaviour:
- Reset (rst=1 at edge): `currAddr`=RESET_ADDR, `stackCount`=0, `stackOvf`=0, `stackUdf`=0. Reset overrides every other input, including mid-call or mid-stall. Stack RAM contents are don't-care after reset.
- All outputs are registered. A request sampled at edge N is visible on `currAddr` after edge N (1-cycle latency).
- Per-edge priority, highest first: rst > stall > retEn > callEn > jmpEn > brEn > increment.
- stall=1: PC, stack, count and flags all hold; every other request is ignored (dropped, not queued).
- retEn, count>0: `currAddr` <= top entry; count decrements.
- retEn, count=0: `stackUdf` <= 1; `currAddr` <= `currAddr`+1; count stays 0.
- callEn, count<STACK_DEPTH: push (`currAddr`+1) mod 2^ADDR_W; `currAddr` <= `callAddr`; count increments.
- callEn, count=STACK_DEPTH: no push, no jump; `stackOvf` <= 1; `currAddr` <= `currAddr`+1.
- jmpEn: `currAddr` <= `jmpAddr`.
- brEn: `currAddr` <= (`currAddr` + `brOffset`) mod 2^ADDR_W. Wraps in both directions.
- Otherwise: `currAddr` <= (`currAddr`+1) mod 2^ADDR_W. Max address wraps to 0.
- Simultaneous retEn+callEn: return wins and the call is dropped. The pushed return address of the lost call does not exist; count changes only by the return.
- Lower-priority requests asserted alongside a higher one are discarded with no side effects.
- Sticky flags clear only on rst.
- Stack pointer never wraps. Overflow and underflow leave stack contents untouched.

Decomposition:
- Shared package `pc_pkg`:
  - next-PC select enum: PC_HOLD, PC_RET, PC_CALL, PC_JMP, PC_BR, PC_INC;
  - default ADDR_W and STACK_DEPTH constants.
- Sub-module `pc_ret_stack`: parametrised LIFO.
  - Ports: clk, rst, push, pop, pushData, topData, count, full, empty.
  - No simultaneous push+pop; the parent guarantees this via priority.
- Top level (`pc_stack`):
  - combinational priority encoder producing the select;
  - registered PC, adder for increment and branch;
  - sticky flag registers.

Test Plan:
- rst=1 one cycle, then 5 idle cycles -> `currAddr` = 0,1,2,3,4,5; `stackCount`=0, flags 0.
- At PC=5: jmpEn, jmpAddr=0x0F0 -> 0x0F0 next cycle, 0x0F1 the following. Then brEn with brOffset=0xFF0 (-16) -> 0x0E1. At PC=0x002, brOffset=0xFFC -> 0xFFE, then 0xFFF, then 0x000 (wrap).
- At PC=0x010: callEn, callAddr=0x200 -> PC=0x200, count=1. Two increments to 0x202, then retEn -> PC=0x011, count=0. Nested: 3 calls then 3 returns -> addresses restored in LIFO order.
- Fill stack with 8 calls, then a 9th call -> `stackOvf`=1, PC = prior+1, count stays 8. Then 9 returns -> 8 correct pops, 9th sets `stackUdf`=1 and PC increments. Both flags persist until rst.
- stall=1 for 3 cycles, with jmpEn/callEn/retEn toggling -> PC, count and flags unchanged. Simultaneous callEn+retEn with count=2 -> pop taken, count=1, call target not loaded.
- rst asserted in the same cycle as callEn at count=4 -> PC=RESET_ADDR, count=0, flags 0, no push. Repeat the full suite at ADDR_W=16, STACK_DEPTH=4, RESET_ADDR=0x100.
